// File: rtl/gerenciador_es_param_if.sv
// Processor-side bus of the I/O manager: syscall strobes, data to display,
// captured switch value and the stall line.
interface gerenciador_es_param_if #(
  parameter int DATA_W = 32
) ();
  logic              SwToReg;
  logic              RegToDisp;
  logic [DATA_W-1:0] dado;
  logic              WAIT;
  logic [DATA_W-1:0] dado_sw32;

  modport master (
    output SwToReg, RegToDisp, dado,
    input  WAIT, dado_sw32
  );

  modport slave (
    input  SwToReg, RegToDisp, dado,
    output WAIT, dado_sw32
  );
endinterface

// File: rtl/gerenciador_es_param.sv
// I/O manager: services the IN syscall (debounced button + switches) and the
// OUT syscall (FIFO-buffered display with a minimum hold time per value).
//
// state | meaning
// IDLE  | no IN pending
// ARMED | IN pending, waiting for a fresh debounced button press
// DONE  | switch value captured, stall released for one cycle
module gerenciador_es_param #(
  parameter int DATA_W      = 32,
  parameter int SW_W        = 16,
  parameter int SIGN_EXT    = 0,
  parameter int OUT_DEPTH   = 4,
  parameter int HOLD_CYCLES = 8,
  parameter int DEB_CYCLES  = 4,
  parameter int DISP_W      = 7,
  localparam int CNT_W      = $clog2(OUT_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  gerenciador_es_param_if.slave cpu,
  input  logic [SW_W-1:0]       switches,
  input  logic                  btn_ok,
  output logic [DATA_W-1:0]     stdout,
  output logic [DISP_W-1:0]     stdout_sat,
  output logic [CNT_W-1:0]      fifo_count
);

  localparam int PTR_W  = $clog2(OUT_DEPTH);
  localparam int TMR_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int DCNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, ARMED, DONE} state_t;

  state_t            state, state_nxt;
  logic              capture;
  logic [SW_W-1:0]   sw_meta, sw_sync;
  logic              btn_meta, btn_sync;
  logic              deb;
  logic [DCNT_W-1:0] dcnt;
  logic              btn_diff, deb_hit, press;
  logic [DATA_W-1:0] sw_ext;
  logic [DATA_W-1:0] mem [OUT_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [TMR_W-1:0]  tmr;
  logic              fifo_full, fifo_empty, push, pop;

  // Two-flop synchronisers for the asynchronous switch and button levels
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_meta  <= '0;
      sw_sync  <= '0;
      btn_meta <= 1'b0;
      btn_sync <= 1'b0;
    end else begin
      sw_meta  <= switches;
      sw_sync  <= sw_meta;
      btn_meta <= btn_ok;
      btn_sync <= btn_meta;
    end
  end

  assign btn_diff = (btn_sync != deb);
  assign deb_hit  = btn_diff && (dcnt == DCNT_W'(DEB_CYCLES - 1));
  // Only a rising debounced edge counts, so a button held on entry never captures
  assign press    = deb_hit && btn_sync;

  // Debouncer: deb follows btn_sync once it has differed for DEB_CYCLES edges
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      deb  <= 1'b0;
      dcnt <= '0;
    end else if (deb_hit) begin
      deb  <= btn_sync;
      dcnt <= '0;
    end else if (btn_diff) begin
      dcnt <= dcnt + DCNT_W'(1);
    end else begin
      dcnt <= '0;
    end
  end

  // Zero or sign extension of the synchronised switches
  always_comb begin
    sw_ext             = {DATA_W{(SIGN_EXT != 0) & sw_sync[SW_W-1]}};
    sw_ext[SW_W-1:0]   = sw_sync;
  end

  // IN FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // IN FSM next state; dropping SwToReg abandons the IN even on a press edge
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      IDLE:  if (cpu.SwToReg) state_nxt = ARMED;
      ARMED: begin
        if (!cpu.SwToReg) begin
          state_nxt = IDLE;
        end else if (press) begin
          capture   = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Captured switch value returned to the register file
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        cpu.dado_sw32 <= '0;
    else if (capture) cpu.dado_sw32 <= sw_ext;
  end

  assign fifo_full  = (fifo_count == CNT_W'(OUT_DEPTH));
  assign fifo_empty = (fifo_count == '0);
  // Fullness uses the pre-edge count: a pop on the same edge does not admit a push
  assign push       = cpu.RegToDisp && !fifo_full;
  assign pop        = (tmr == '0) && !fifo_empty;

  assign cpu.WAIT = (cpu.SwToReg && (state != DONE)) || (cpu.RegToDisp && fifo_full);

  // Output FIFO, hold timer and displayed value
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < OUT_DEPTH; i++) mem[i] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      tmr        <= '0;
      stdout     <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= cpu.dado;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        stdout <= mem[rd_ptr];
        rd_ptr <= rd_ptr + PTR_W'(1);
        tmr    <= TMR_W'(HOLD_CYCLES - 1);
      end else if (tmr != '0) begin
        tmr <= tmr - TMR_W'(1);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Saturate to all ones when the value does not fit the display width
  assign stdout_sat = ((stdout >> DISP_W) == '0) ? stdout[DISP_W-1:0] : '1;

endmodule

// File: tb/tb_gerenciador_es_param.sv
// Directed bench for the I/O manager: two instances, zero- and sign-extending.
module tb_gerenciador_es_param;

  logic        clk;
  logic        reset;
  logic [15:0] switches;
  logic        btn_ok;
  logic [31:0] stdout_z, stdout_s;
  logic [6:0]  sat_z, sat_s;
  logic [2:0]  cnt_z, cnt_s;
  int          checks;
  int          errors;

  gerenciador_es_param_if #(.DATA_W(32)) cpu_z ();
  gerenciador_es_param_if #(.DATA_W(32)) cpu_s ();

  gerenciador_es_param #(
    .DATA_W(32), .SW_W(16), .SIGN_EXT(0), .OUT_DEPTH(4),
    .HOLD_CYCLES(4), .DEB_CYCLES(3), .DISP_W(7)
  ) u_dut_z (
    .clk(clk), .reset(reset), .cpu(cpu_z.slave),
    .switches(switches), .btn_ok(btn_ok),
    .stdout(stdout_z), .stdout_sat(sat_z), .fifo_count(cnt_z)
  );

  gerenciador_es_param #(
    .DATA_W(32), .SW_W(16), .SIGN_EXT(1), .OUT_DEPTH(4),
    .HOLD_CYCLES(4), .DEB_CYCLES(3), .DISP_W(7)
  ) u_dut_s (
    .clk(clk), .reset(reset), .cpu(cpu_s.slave),
    .switches(switches), .btn_ok(btn_ok),
    .stdout(stdout_s), .stdout_sat(sat_s), .fifo_count(cnt_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset;
    @(negedge clk);
    checks++; if (stdout_z !== 32'd0) begin errors++; $display("FAIL reset_stdout got %h exp 0", stdout_z); end
    checks++; if (sat_z !== 7'd0) begin errors++; $display("FAIL reset_sat got %h exp 0", sat_z); end
    checks++; if (cnt_z !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", cnt_z); end
    checks++; if (cpu_z.dado_sw32 !== 32'd0) begin errors++; $display("FAIL reset_dado_sw32 got %h exp 0", cpu_z.dado_sw32); end
    checks++; if (cpu_z.WAIT !== 1'b0) begin errors++; $display("FAIL reset_wait_idle got %b exp 0", cpu_z.WAIT); end
    cpu_z.SwToReg = 1'b1;
    #1;
    checks++; if (cpu_z.WAIT !== 1'b1) begin errors++; $display("FAIL reset_wait_swtoreg got %b exp 1", cpu_z.WAIT); end
    cpu_z.SwToReg = 1'b0;
    #1;
    reset = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_in_zero;
    int  high_n;
    bit  done;
    switches      = 16'h8005;
    cpu_z.SwToReg = 1'b1;
    btn_ok        = 1'b1;
    high_n = 0;
    done   = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (cpu_z.WAIT) high_n++;
      else done = 1'b1;
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL in_zero_timeout got %b exp 1", done); end
    checks++; if (high_n !== 4) begin errors++; $display("FAIL in_zero_latency got %0d exp 4", high_n); end
    checks++; if (cpu_z.dado_sw32 !== 32'h0000_8005) begin errors++; $display("FAIL in_zero_value got %h exp 00008005", cpu_z.dado_sw32); end
    @(negedge clk);
    checks++; if (cpu_z.WAIT !== 1'b1) begin errors++; $display("FAIL in_zero_b2b_wait got %b exp 1", cpu_z.WAIT); end
    cpu_z.SwToReg = 1'b0;
    switches      = 16'h1234;
    repeat (4) @(negedge clk);
    btn_ok = 1'b0;
    repeat (8) @(negedge clk);
    checks++; if (cpu_z.dado_sw32 !== 32'h0000_8005) begin errors++; $display("FAIL in_zero_single got %h exp 00008005", cpu_z.dado_sw32); end
  endtask

  task automatic test_in_sign_ext;
    int  high_n;
    bit  done;
    switches      = 16'h8005;
    cpu_s.SwToReg = 1'b1;
    btn_ok        = 1'b1;
    high_n = 0;
    done   = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (cpu_s.WAIT) high_n++;
      else done = 1'b1;
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL in_sign_timeout got %b exp 1", done); end
    checks++; if (high_n !== 4) begin errors++; $display("FAIL in_sign_latency got %0d exp 4", high_n); end
    checks++; if (cpu_s.dado_sw32 !== 32'hFFFF_8005) begin errors++; $display("FAIL in_sign_value got %h exp ffff8005", cpu_s.dado_sw32); end
    @(negedge clk);
    cpu_s.SwToReg = 1'b0;
    repeat (4) @(negedge clk);
    btn_ok = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_glitch;
    int bad;
    bad           = 0;
    switches      = 16'h0F0F;
    cpu_z.SwToReg = 1'b1;
    @(negedge clk);
    btn_ok = 1'b1;
    repeat (2) @(negedge clk);
    btn_ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (cpu_z.WAIT !== 1'b1) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL glitch_wait low_cycles %0d exp 0", bad); end
    checks++; if (cpu_z.dado_sw32 !== 32'h0000_8005) begin errors++; $display("FAIL glitch_capture got %h exp 00008005", cpu_z.dado_sw32); end
    cpu_z.SwToReg = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_held_button;
    int  bad;
    int  high_n;
    bit  done;
    btn_ok = 1'b1;
    repeat (8) @(negedge clk);
    switches      = 16'h7A5C;
    cpu_z.SwToReg = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (cpu_z.WAIT !== 1'b1) bad++;
    end
    checks++; if (cpu_z.dado_sw32 !== 32'h0000_8005) begin errors++; $display("FAIL held_no_capture got %h exp 00008005", cpu_z.dado_sw32); end
    btn_ok = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (cpu_z.WAIT !== 1'b1) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL held_wait low_cycles %0d exp 0", bad); end
    btn_ok = 1'b1;
    high_n = 0;
    done   = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (cpu_z.WAIT) high_n++;
      else done = 1'b1;
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL held_timeout got %b exp 1", done); end
    checks++; if (high_n !== 4) begin errors++; $display("FAIL held_latency got %0d exp 4", high_n); end
    checks++; if (cpu_z.dado_sw32 !== 32'h0000_7A5C) begin errors++; $display("FAIL held_value got %h exp 00007a5c", cpu_z.dado_sw32); end
    @(negedge clk);
    cpu_z.SwToReg = 1'b0;
    btn_ok        = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_out_burst;
    logic [31:0] vals [6];
    logic [31:0] seen [6];
    logic [31:0] prev;
    int  idx, seen_n, hold, bad_hold, wait_n, bad_full, max_cnt, bad_sat, sat200_n, bad_seq;
    bit  pend;
    vals = '{32'd1, 32'd2, 32'd3, 32'd200, 32'd5, 32'd6};
    for (int i = 0; i < 6; i++) seen[i] = '0;
    idx = 0; seen_n = 0; hold = 0; bad_hold = 0; wait_n = 0; bad_full = 0;
    max_cnt = 0; bad_sat = 0; sat200_n = 0; bad_seq = 0;
    prev            = stdout_z;
    cpu_z.dado      = vals[0];
    cpu_z.RegToDisp = 1'b1;
    #1;
    pend = cpu_z.RegToDisp && !cpu_z.WAIT;
    for (int c = 0; c < 60 && seen_n < 6; c++) begin
      @(negedge clk);
      if (pend) begin
        idx++;
        if (idx == 6) cpu_z.RegToDisp = 1'b0;
        else          cpu_z.dado = vals[idx];
      end
      #1;
      pend = cpu_z.RegToDisp && !cpu_z.WAIT;
      if (cpu_z.WAIT) begin
        wait_n++;
        if (cnt_z !== 3'd4) bad_full++;
      end
      if (int'(cnt_z) > max_cnt) max_cnt = int'(cnt_z);
      if (stdout_z == 32'd200) begin
        sat200_n++;
        if (sat_z !== 7'd127) bad_sat++;
      end else if (sat_z !== stdout_z[6:0]) begin
        bad_sat++;
      end
      if (stdout_z !== prev) begin
        if (seen_n > 0 && hold != 4) bad_hold++;
        seen[seen_n] = stdout_z;
        seen_n++;
        hold = 1;
        prev = stdout_z;
      end else begin
        hold++;
      end
    end
    cpu_z.RegToDisp = 1'b0;
    for (int i = 0; i < 6; i++) if (seen[i] !== vals[i]) bad_seq++;
    checks++; if (seen_n !== 6) begin errors++; $display("FAIL out_values_shown got %0d exp 6", seen_n); end
    checks++; if (bad_seq !== 0) begin errors++; $display("FAIL out_sequence wrong_entries %0d exp 0", bad_seq); end
    checks++; if (bad_hold !== 0) begin errors++; $display("FAIL out_hold wrong_holds %0d exp 0", bad_hold); end
    checks++; if (wait_n !== 1) begin errors++; $display("FAIL out_wait_cycles got %0d exp 1", wait_n); end
    checks++; if (bad_full !== 0) begin errors++; $display("FAIL out_wait_not_full got %0d exp 0", bad_full); end
    checks++; if (max_cnt !== 4) begin errors++; $display("FAIL out_max_count got %0d exp 4", max_cnt); end
    checks++; if (sat200_n !== 4) begin errors++; $display("FAIL out_sat200_cycles got %0d exp 4", sat200_n); end
    checks++; if (bad_sat !== 0) begin errors++; $display("FAIL out_sat wrong_cycles %0d exp 0", bad_sat); end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    logic [31:0] vals [4];
    vals = '{32'd10, 32'd11, 32'd12, 32'd13};
    for (int i = 0; i < 4; i++) begin
      cpu_z.dado      = vals[i];
      cpu_z.RegToDisp = 1'b1;
      @(negedge clk);
    end
    cpu_z.RegToDisp = 1'b0;
    cpu_z.SwToReg   = 1'b1;
    @(negedge clk);
    checks++; if (cnt_z !== 3'd3) begin errors++; $display("FAIL rst_mid_pre_count got %0d exp 3", cnt_z); end
    checks++; if (stdout_z !== 32'd10) begin errors++; $display("FAIL rst_mid_pre_stdout got %0d exp 10", stdout_z); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (stdout_z !== 32'd0) begin errors++; $display("FAIL rst_mid_stdout got %h exp 0", stdout_z); end
    checks++; if (sat_z !== 7'd0) begin errors++; $display("FAIL rst_mid_sat got %h exp 0", sat_z); end
    checks++; if (cnt_z !== 3'd0) begin errors++; $display("FAIL rst_mid_count got %0d exp 0", cnt_z); end
    checks++; if (cpu_z.dado_sw32 !== 32'd0) begin errors++; $display("FAIL rst_mid_dado_sw32 got %h exp 0", cpu_z.dado_sw32); end
    checks++; if (cpu_z.WAIT !== 1'b1) begin errors++; $display("FAIL rst_mid_wait got %b exp 1", cpu_z.WAIT); end
    @(negedge clk);
    reset         = 1'b0;
    cpu_z.SwToReg = 1'b0;
    @(negedge clk);
    checks++; if (cnt_z !== 3'd0) begin errors++; $display("FAIL rst_mid_empty got %0d exp 0", cnt_z); end
    cpu_z.dado      = 32'd9;
    cpu_z.RegToDisp = 1'b1;
    @(negedge clk);
    cpu_z.RegToDisp = 1'b0;
    #1;
    checks++; if (stdout_z !== 32'd0) begin errors++; $display("FAIL rst_mid_push_stdout got %0d exp 0", stdout_z); end
    checks++; if (cnt_z !== 3'd1) begin errors++; $display("FAIL rst_mid_push_count got %0d exp 1", cnt_z); end
    @(negedge clk);
    checks++; if (stdout_z !== 32'd9) begin errors++; $display("FAIL rst_mid_show9 got %0d exp 9", stdout_z); end
    checks++; if (sat_z !== 7'd9) begin errors++; $display("FAIL rst_mid_sat9 got %0d exp 9", sat_z); end
    checks++; if (cnt_z !== 3'd0) begin errors++; $display("FAIL rst_mid_pop_count got %0d exp 0", cnt_z); end
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    reset           = 1'b1;
    switches        = '0;
    btn_ok          = 1'b0;
    cpu_z.SwToReg   = 1'b0;
    cpu_z.RegToDisp = 1'b0;
    cpu_z.dado      = '0;
    cpu_s.SwToReg   = 1'b0;
    cpu_s.RegToDisp = 1'b0;
    cpu_s.dado      = '0;
    test_reset;
    test_in_zero;
    test_in_sign_ext;
    test_glitch;
    test_held_button;
    test_out_burst;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
